pipe_front_regs: RTL and testbench

//  Front-end pipeline state that acts on the hazard unit's outputs: PC register, IF/ID register and
//  the ID/EX fields the hazard unit reads back (Rt, MemRead) plus ID/EX control word.

---
 rtl/pipe_front_regs.sv | 189 ++++++++++++++++++
 tb/tb_pipe_front_regs.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_front_regs.sv
// ---------------------------------------------------------------------------
// pipe_front_regs
//
// Front-end pipeline state of a 5-stage MIPS pipeline:
// - the PC register;
// - the IF/ID register;
// - the ID/EX fields the hazard unit reads back (Rt, MemRead), plus the ID/EX
//   control word.
//
// The block acts on the hazard unit's PC hold, IF/ID hold and ID/EX bubble
// requests and on a branch flush. A stall watchdog raises a sticky error when
// the pipeline stays stalled for too long.
//
// Optional feature macro: STALL_PERF_EN
//   defined   -> 32-bit wrapping stall-cycle and bubble counters are built.
//   undefined -> stall_cnt_o and bubble_cnt_o are tied to zero.
//
// Ports:
//   clk_i, rst_i        clock; synchronous active-high reset
//   pc_next_i           next PC from the PC mux
//   instr_i             instruction fetched at pc_o
//   pc_hold_i           hold the PC register
//   if_id_hold_i        hold the IF/ID register
//   bubble_i            zero the ID/EX control, Rt and MemRead fields
//   flush_i             branch taken in ID: squash IF/ID and load pc_next_i
//   ctrl_i              decoded control word for ID/EX
//   rt_i                Rt field for ID/EX
//   memread_i           MemRead for ID/EX
//   pc_o                current PC
//   if_id_pc4_o         PC+4 of the instruction in IF/ID
//   if_id_instr_o       instruction in IF/ID
//   if_id_valid_o       IF/ID holds a real instruction
//   id_ex_ctrl_o        ID/EX control word
//   id_ex_rt_o          ID/EX Rt
//   id_ex_memread_o     ID/EX MemRead
//   stall_err_o         sticky stall-watchdog error
//   stall_cnt_o         total stall cycles
//   bubble_cnt_o        total bubbles inserted
//
// All outputs are registered.
// ---------------------------------------------------------------------------
module pipe_front_regs #(
  parameter logic [31:0] RESET_PC  = 32'h0,
  parameter int          CTRL_W    = 8,
  parameter int          MAX_STALL = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [31:0]       pc_next_i,
  input  logic [31:0]       instr_i,
  input  logic              pc_hold_i,
  input  logic              if_id_hold_i,
  input  logic              bubble_i,
  input  logic              flush_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [4:0]        rt_i,
  input  logic              memread_i,
  output logic [31:0]       pc_o,
  output logic [31:0]       if_id_pc4_o,
  output logic [31:0]       if_id_instr_o,
  output logic              if_id_valid_o,
  output logic [CTRL_W-1:0] id_ex_ctrl_o,
  output logic [4:0]        id_ex_rt_o,
  output logic              id_ex_memread_o,
  output logic              stall_err_o,
  output logic [31:0]       stall_cnt_o,
  output logic [31:0]       bubble_cnt_o
);

  // The counter needs room to count up to MAX_STALL and then saturate.
  localparam int RUN_W = $clog2(MAX_STALL + 2);
  localparam logic [RUN_W-1:0] RUN_LIMIT = RUN_W'(MAX_STALL);

  logic [31:0]       pc_q, pc_d;
  logic [31:0]       if_id_pc4_q, if_id_pc4_d;
  logic [31:0]       if_id_instr_q, if_id_instr_d;
  logic              if_id_valid_q, if_id_valid_d;
  logic [CTRL_W-1:0] id_ex_ctrl_q, id_ex_ctrl_d;
  logic [4:0]        id_ex_rt_q, id_ex_rt_d;
  logic              id_ex_memread_q, id_ex_memread_d;
  logic [RUN_W-1:0]  run_q, run_d;
  logic              stall_err_q, stall_err_d;
  logic              stalled;

  assign stalled = pc_hold_i | if_id_hold_i;

  always_comb begin
    // PC: a flush overrides a hold, because the branch redirect must land.
    pc_d = pc_next_i;
    if (!flush_i && pc_hold_i) begin
      pc_d = pc_q;
    end

    // IF/ID: a flush squashes to a NOP, a hold keeps all three fields, and
    // otherwise the register captures the fetch. PC+4 wraps naturally at 2^32.
    if_id_pc4_d   = pc_q + 32'd4;
    if_id_instr_d = instr_i;
    if_id_valid_d = 1'b1;
    if (flush_i) begin
      if_id_pc4_d   = 32'h0;
      if_id_instr_d = 32'h0;
      if_id_valid_d = 1'b0;
    end else if (if_id_hold_i) begin
      if_id_pc4_d   = if_id_pc4_q;
      if_id_instr_d = if_id_instr_q;
      if_id_valid_d = if_id_valid_q;
    end

    // ID/EX: only a bubble changes this stage. The branch that caused a
    // flush is already in ID, so it still proceeds to EX.
    id_ex_ctrl_d    = ctrl_i;
    id_ex_rt_d      = rt_i;
    id_ex_memread_d = memread_i;
    if (bubble_i) begin
      id_ex_ctrl_d    = '0;
      id_ex_rt_d      = 5'd0;
      id_ex_memread_d = 1'b0;
    end

    // Watchdog: count consecutive stalled cycles (saturating). A flush
    // breaks the run. The error fires when a cycle is still stalled after
    // MAX_STALL stalled cycles have already been counted.
    run_d = '0;
    if (stalled && !flush_i) begin
      run_d = (run_q == '1) ? run_q : run_q + 1'b1;
    end
    stall_err_d = stall_err_q | (stalled && (run_q >= RUN_LIMIT));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q            <= RESET_PC;
      if_id_pc4_q     <= 32'h0;
      if_id_instr_q   <= 32'h0;
      if_id_valid_q   <= 1'b0;
      id_ex_ctrl_q    <= '0;
      id_ex_rt_q      <= 5'd0;
      id_ex_memread_q <= 1'b0;
      run_q           <= '0;
      stall_err_q     <= 1'b0;
    end else begin
      pc_q            <= pc_d;
      if_id_pc4_q     <= if_id_pc4_d;
      if_id_instr_q   <= if_id_instr_d;
      if_id_valid_q   <= if_id_valid_d;
      id_ex_ctrl_q    <= id_ex_ctrl_d;
      id_ex_rt_q      <= id_ex_rt_d;
      id_ex_memread_q <= id_ex_memread_d;
      run_q           <= run_d;
      stall_err_q     <= stall_err_d;
    end
  end

`ifdef STALL_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] bubble_cnt_q, bubble_cnt_d;

  always_comb begin
    stall_cnt_d  = stall_cnt_q + {31'd0, stalled};
    bubble_cnt_d = bubble_cnt_q + {31'd0, bubble_i};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q  <= 32'h0;
      bubble_cnt_q <= 32'h0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign stall_cnt_o  = stall_cnt_q;
  assign bubble_cnt_o = bubble_cnt_q;
`else
  assign stall_cnt_o  = 32'h0;
  assign bubble_cnt_o = 32'h0;
`endif

  assign pc_o            = pc_q;
  assign if_id_pc4_o     = if_id_pc4_q;
  assign if_id_instr_o   = if_id_instr_q;
  assign if_id_valid_o   = if_id_valid_q;
  assign id_ex_ctrl_o    = id_ex_ctrl_q;
  assign id_ex_rt_o      = id_ex_rt_q;
  assign id_ex_memread_o = id_ex_memread_q;
  assign stall_err_o     = stall_err_q;

endmodule

// File: tb/tb_pipe_front_regs.sv
// ---------------------------------------------------------------------------
// tb_pipe_front_regs
//
// Directed testbench for pipe_front_regs:
// - reset state;
// - normal advance;
// - load-use stall with a bubble;
// - flush overriding holds;
// - stall watchdog, including its stickiness and its clear on reset;
// - PC+4 wrap;
// - performance counters.
//
// Expected counter values follow STALL_PERF_EN.
// ---------------------------------------------------------------------------
module tb_pipe_front_regs;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] pc_next_i;
  logic [31:0] instr_i;
  logic        pc_hold_i;
  logic        if_id_hold_i;
  logic        bubble_i;
  logic        flush_i;
  logic [7:0]  ctrl_i;
  logic [4:0]  rt_i;
  logic        memread_i;
  logic [31:0] pc_o;
  logic [31:0] if_id_pc4_o;
  logic [31:0] if_id_instr_o;
  logic        if_id_valid_o;
  logic [7:0]  id_ex_ctrl_o;
  logic [4:0]  id_ex_rt_o;
  logic        id_ex_memread_o;
  logic        stall_err_o;
  logic [31:0] stall_cnt_o;
  logic [31:0] bubble_cnt_o;

  int n_checks = 0;
  int n_pass   = 0;

  pipe_front_regs #(
    .RESET_PC  (32'h0),
    .CTRL_W    (8),
    .MAX_STALL (2)
  ) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .pc_next_i       (pc_next_i),
    .instr_i         (instr_i),
    .pc_hold_i       (pc_hold_i),
    .if_id_hold_i    (if_id_hold_i),
    .bubble_i        (bubble_i),
    .flush_i         (flush_i),
    .ctrl_i          (ctrl_i),
    .rt_i            (rt_i),
    .memread_i       (memread_i),
    .pc_o            (pc_o),
    .if_id_pc4_o     (if_id_pc4_o),
    .if_id_instr_o   (if_id_instr_o),
    .if_id_valid_o   (if_id_valid_o),
    .id_ex_ctrl_o    (id_ex_ctrl_o),
    .id_ex_rt_o      (id_ex_rt_o),
    .id_ex_memread_o (id_ex_memread_o),
    .stall_err_o     (stall_err_o),
    .stall_cnt_o     (stall_cnt_o),
    .bubble_cnt_o    (bubble_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one edge, then settle away from it before checking or driving.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic [31:0] pcn, input logic [31:0] ins, input logic ph,
                       input logic ih, input logic bub, input logic fl,
                       input logic [7:0] ctl, input logic [4:0] rt, input logic mr);
    pc_next_i    = pcn;
    instr_i      = ins;
    pc_hold_i    = ph;
    if_id_hold_i = ih;
    bubble_i     = bub;
    flush_i      = fl;
    ctrl_i       = ctl;
    rt_i         = rt;
    memread_i    = mr;
  endtask

  task automatic check_ifid(input string tag, input logic [31:0] pc4,
                            input logic [31:0] ins, input logic vld);
    check_val({tag, "_pc4"},   if_id_pc4_o,   pc4);
    check_val({tag, "_instr"}, if_id_instr_o, ins);
    check_val({tag, "_valid"}, {31'd0, if_id_valid_o}, {31'd0, vld});
  endtask

  task automatic check_idex(input string tag, input logic [7:0] ctl,
                            input logic [4:0] rt, input logic mr);
    check_val({tag, "_ctrl"}, {24'd0, id_ex_ctrl_o}, {24'd0, ctl});
    check_val({tag, "_rt"},   {27'd0, id_ex_rt_o},   {27'd0, rt});
    check_val({tag, "_mr"},   {31'd0, id_ex_memread_o}, {31'd0, mr});
  endtask

  function automatic logic [31:0] perf(input logic [31:0] v);
`ifdef STALL_PERF_EN
    return v;
`else
    return 32'h0 & v;
`endif
  endfunction

  initial begin
    // Reset with non-zero inputs: reset must dominate them.
    rst_i = 1'b1;
    drive(32'h100, 32'hDEADBEEF, 1'b1, 1'b1, 1'b1, 1'b0, 8'hFF, 5'd31, 1'b1);
    step();
    step();
    check_val("rst_pc", pc_o, 32'h0);
    check_ifid("rst", 32'h0, 32'h0, 1'b0);
    check_idex("rst", 8'h0, 5'd0, 1'b0);
    check_val("rst_err", {31'd0, stall_err_o}, 32'd0);
    check_val("rst_scnt", stall_cnt_o, 32'h0);
    check_val("rst_bcnt", bubble_cnt_o, 32'h0);
    $display("txn reset: pc=%08h valid=%0d", pc_o, if_id_valid_o);

    // 1: normal advance.
    rst_i = 1'b0;
    drive(32'h4, 32'h8C010000, 1'b0, 1'b0, 1'b0, 1'b0, 8'h5A, 5'd3, 1'b0);
    step();
    check_val("adv1_pc", pc_o, 32'h4);
    check_ifid("adv1", 32'h4, 32'h8C010000, 1'b1);
    check_idex("adv1", 8'h5A, 5'd3, 1'b0);
    $display("txn advance1: pc=%08h pc4=%08h", pc_o, if_id_pc4_o);
    drive(32'h8, 32'h00221820, 1'b0, 1'b0, 1'b0, 1'b0, 8'h5A, 5'd3, 1'b0);
    step();
    check_val("adv2_pc", pc_o, 32'h8);
    check_ifid("adv2", 32'h8, 32'h00221820, 1'b1);
    $display("txn advance2: pc=%08h pc4=%08h", pc_o, if_id_pc4_o);

    // 2: load-use stall for one cycle with a bubble.
    drive(32'hC, 32'h12345678, 1'b1, 1'b1, 1'b1, 1'b0, 8'hA5, 5'd5, 1'b1);
    step();
    check_val("lu_pc", pc_o, 32'h8);
    check_ifid("lu", 32'h8, 32'h00221820, 1'b1);
    check_idex("lu", 8'h0, 5'd0, 1'b0);
    $display("txn load-use: pc=%08h ctrl=%02h", pc_o, id_ex_ctrl_o);
    drive(32'hC, 32'h12345678, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 5'd5, 1'b1);
    step();
    check_val("resume_pc", pc_o, 32'hC);
    check_ifid("resume", 32'hC, 32'h12345678, 1'b1);
    check_idex("resume", 8'hA5, 5'd5, 1'b1);
    check_val("resume_err", {31'd0, stall_err_o}, 32'd0);
    check_val("lu_scnt", stall_cnt_o, perf(32'd1));
    check_val("lu_bcnt", bubble_cnt_o, perf(32'd1));
    $display("txn resume: pc=%08h ctrl=%02h", pc_o, id_ex_ctrl_o);

    // 3: a flush overrides both holds; ID/EX is unaffected by the flush.
    drive(32'h40, 32'hAAAA5555, 1'b1, 1'b1, 1'b0, 1'b1, 8'h11, 5'd7, 1'b0);
    step();
    check_val("fl_pc", pc_o, 32'h40);
    check_ifid("fl", 32'h0, 32'h0, 1'b0);
    check_idex("fl", 8'h11, 5'd7, 1'b0);
    $display("txn flush: pc=%08h valid=%0d", pc_o, if_id_valid_o);

    // 4: watchdog. Three consecutive stalled edges set the sticky error.
    drive(32'h44, 32'h0BADF00D, 1'b1, 1'b1, 1'b0, 1'b0, 8'h22, 5'd1, 1'b0);
    step();
    check_val("wd1_err", {31'd0, stall_err_o}, 32'd0);
    step();
    check_val("wd2_err", {31'd0, stall_err_o}, 32'd0);
    step();
    check_val("wd3_err", {31'd0, stall_err_o}, 32'd1);
    check_val("wd_pc", pc_o, 32'h40);
    check_val("wd_valid", {31'd0, if_id_valid_o}, 32'd0);
    check_val("wd_scnt", stall_cnt_o, perf(32'd5));
    $display("txn watchdog: err=%0d scnt=%0d", stall_err_o, stall_cnt_o);
    drive(32'h44, 32'h0BADF00D, 1'b0, 1'b0, 1'b0, 1'b0, 8'h22, 5'd1, 1'b0);
    step();
    step();
    check_val("sticky_err", {31'd0, stall_err_o}, 32'd1);
    check_val("sticky_pc", pc_o, 32'h44);
    $display("txn sticky: err=%0d pc=%08h", stall_err_o, pc_o);
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    check_val("clr_err", {31'd0, stall_err_o}, 32'd0);
    check_val("clr_scnt", stall_cnt_o, 32'h0);
    $display("txn reset2: err=%0d", stall_err_o);

    // 5: PC+4 wraps modulo 2^32.
    drive(32'hFFFFFFFC, 32'h11112222, 1'b0, 1'b0, 1'b0, 1'b0, 8'h0, 5'd0, 1'b0);
    step();
    check_val("wrap_pc", pc_o, 32'hFFFFFFFC);
    drive(32'h0, 32'h33334444, 1'b0, 1'b0, 1'b0, 1'b0, 8'h0, 5'd0, 1'b0);
    step();
    check_ifid("wrap", 32'h0, 32'h33334444, 1'b1);
    $display("txn wrap: pc4=%08h", if_id_pc4_o);

    // 6: two stalled cycles (PC hold only, then IF/ID hold only) and one
    // separate bubble cycle.
    drive(32'h8, 32'h55556666, 1'b1, 1'b0, 1'b0, 1'b0, 8'h0, 5'd0, 1'b0);
    step();
    check_val("ph_pc", pc_o, 32'h0);
    check_ifid("ph", 32'h4, 32'h55556666, 1'b1);
    drive(32'h8, 32'h77778888, 1'b0, 1'b1, 1'b0, 1'b0, 8'h0, 5'd0, 1'b0);
    step();
    check_val("ih_pc", pc_o, 32'h8);
    check_ifid("ih", 32'h4, 32'h55556666, 1'b1);
    drive(32'hC, 32'h9999AAAA, 1'b0, 1'b0, 1'b1, 1'b0, 8'h33, 5'd9, 1'b1);
    step();
    check_idex("bub", 8'h0, 5'd0, 1'b0);
    check_val("perf_scnt", stall_cnt_o, perf(32'd2));
    check_val("perf_bcnt", bubble_cnt_o, perf(32'd1));
    check_val("perf_err", {31'd0, stall_err_o}, 32'd0);
    $display("txn perf: scnt=%0d bcnt=%0d", stall_cnt_o, bubble_cnt_o);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
